// File: rtl/mips_trace_checker.sv
// mips_trace_checker: compares sampled MIPS retirements against a
// host-loaded golden table of (mode, PC, writedata) entries.
module mips_trace_checker #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [1:0]        ld_mode,
  input  logic [ADDR_W-1:0] ld_pc,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic              abort,
  input  logic              sample_en,
  input  logic [ADDR_W-1:0] dut_pc,
  input  logic [DATA_W-1:0] dut_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              fail_valid,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [ADDR_W-1:0] fail_pc,
  output logic [DATA_W-1:0] fail_data
);

  localparam logic [1:0] M_SKIP = 2'b00;
  localparam logic [1:0] M_PC   = 2'b01;
  localparam logic [1:0] M_PCD  = 2'b10;
  localparam logic [1:0] M_END  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]        r_mode [DEPTH];
  logic [ADDR_W-1:0] r_pc   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic [IDX_W-1:0]  r_idx;
  logic              r_mm;
  logic [ERR_W-1:0]  r_err;
  logic              r_fv;
  logic [IDX_W-1:0]  r_fidx;
  logic [ADDR_W-1:0] r_fpc;
  logic [DATA_W-1:0] r_fdata;

  logic [1:0]        w_mode;
  logic [ADDR_W-1:0] w_pc;
  logic [DATA_W-1:0] w_data;
  logic              w_act;
  logic              w_cmp;
  logic              w_fail;
  logic              w_last;
  logic              w_enter;
  logic              w_wr;

  assign w_mode  = r_mode[r_idx];
  assign w_pc    = r_pc[r_idx];
  assign w_data  = r_data[r_idx];
  assign w_act   = (r_state == S_RUN) && sample_en && !abort;
  assign w_cmp   = w_act && (w_mode == M_PC || w_mode == M_PCD);
  assign w_fail  = w_cmp && ((dut_pc != w_pc) ||
                   (w_mode == M_PCD && dut_data != w_data));
  assign w_last  = (r_idx == IDX_W'(DEPTH - 1));
  assign w_enter = (r_state != S_RUN) && (w_next == S_RUN);
  assign w_wr    = ld_en && (r_state == S_IDLE);

  // Table RAM has no reset; the host reloads it.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mode[ld_idx] <= ld_mode;
      r_pc[ld_idx]   <= ld_pc;
      r_data[ld_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) w_next = S_RUN;
        S_RUN:  if (w_act && (w_mode == M_END || w_last))
                  w_next = S_DONE;
        S_DONE: if (start) w_next = S_RUN;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
    pass = done && (r_err == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_mm    <= 1'b0;
      r_err   <= '0;
      r_fv    <= 1'b0;
      r_fidx  <= '0;
      r_fpc   <= '0;
      r_fdata <= '0;
    end else if (w_enter) begin
      r_idx   <= '0;
      r_mm    <= 1'b0;
      r_err   <= '0;
      r_fv    <= 1'b0;
      r_fidx  <= '0;
      r_fpc   <= '0;
      r_fdata <= '0;
    end else begin
      r_mm <= w_fail;
      // idx sticks at the last entry instead of wrapping
      if (w_act && w_mode != M_END && !w_last)
        r_idx <= r_idx + 1'b1;
      if (w_fail && r_err != '1)
        r_err <= r_err + 1'b1;
      if (w_fail && !r_fv) begin
        r_fv    <= 1'b1;
        r_fidx  <= r_idx;
        r_fpc   <= dut_pc;
        r_fdata <= dut_data;
      end
    end
  end

  assign mismatch   = r_mm;
  assign err_cnt    = r_err;
  assign fail_valid = r_fv;
  assign fail_idx   = r_fidx;
  assign fail_pc    = r_fpc;
  assign fail_data  = r_fdata;

endmodule

// File: tb/tb_mips_trace_checker.sv
// tb_mips_trace_checker: directed table-driven bench for the
// golden-trace checker, run with a 512-entry table.
module tb_mips_trace_checker;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 512;
  localparam int IW = 9;
  localparam int EW = 8;

  localparam logic [1:0] MS = 2'b00;
  localparam logic [1:0] MP = 2'b01;
  localparam logic [1:0] MD = 2'b10;
  localparam logic [1:0] ME = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_en = 1'b0;
  logic [IW-1:0] ld_idx = '0;
  logic [1:0]    ld_mode = '0;
  logic [AW-1:0] ld_pc = '0;
  logic [DW-1:0] ld_data = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sample_en = 1'b0;
  logic [AW-1:0] dut_pc = '0;
  logic [DW-1:0] dut_data = '0;
  logic          busy, done, pass, mismatch, fail_valid;
  logic [EW-1:0] err_cnt;
  logic [IW-1:0] fail_idx;
  logic [AW-1:0] fail_pc;
  logic [DW-1:0] fail_data;

  mips_trace_checker #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH),
    .IDX_W(IW), .ERR_W(EW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_mode(ld_mode),
    .ld_pc(ld_pc), .ld_data(ld_data),
    .start(start), .abort(abort),
    .sample_en(sample_en), .dut_pc(dut_pc), .dut_data(dut_data),
    .busy(busy), .done(done), .pass(pass),
    .mismatch(mismatch), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_idx(fail_idx),
    .fail_pc(fail_pc), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        se;
    logic [31:0] pc;
    logic [31:0] dat;
    logic        mm;
    logic [7:0]  err;
  } vec_t;

  vec_t        q[$];
  int unsigned pdat [17];
  logic [1:0]  pmode [17];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".pass"}, pass, 0);
    chk({nm, ".mm"}, mismatch, 0);
    chk({nm, ".err"}, err_cnt, 0);
    chk({nm, ".fv"}, fail_valid, 0);
    chk({nm, ".fidx"}, fail_idx, 0);
    chk({nm, ".fpc"}, fail_pc, 0);
    chk({nm, ".fdata"}, fail_data, 0);
  endtask

  task automatic load(input int idx, input logic [1:0] m,
                      input logic [31:0] p, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_idx = IW'(idx);
    ld_mode = m;
    ld_pc = p;
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 17; i++)
      load(i, pmode[i], 32'(4 * i), pdat[i]);
    load(17, ME, 32'd0, 32'd0);
  endtask

  task automatic start_run(input string nm);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, ".busy_on_start"}, busy, 1);
  endtask

  task automatic build_good();
    vec_t v;
    q.delete();
    for (int i = 0; i < 17; i++) begin
      v.se = 1'b1;
      v.pc = (pmode[i] == MS) ? 32'd999 : 32'(4 * i);
      v.dat = (pmode[i] == MS) ? 32'd999 :
              (pmode[i] == MP) ? 32'd12345 : pdat[i];
      v.mm = 1'b0;
      v.err = 8'd0;
      q.push_back(v);
    end
    v.se = 1'b1;
    v.pc = 32'h500;
    v.dat = 32'h0;
    v.mm = 1'b0;
    v.err = 8'd0;
    q.push_back(v);
  endtask

  task automatic apply(input string nm);
    int last;
    last = q.size() - 1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      sample_en = q[k].se;
      dut_pc = q[k].pc;
      dut_data = q[k].dat;
      @(posedge clk);
      #1;
      chk($sformatf("%s.mm[%0d]", nm, k), mismatch, q[k].mm);
      chk($sformatf("%s.err[%0d]", nm, k), err_cnt, q[k].err);
      chk($sformatf("%s.busy[%0d]", nm, k), busy, k != last);
    end
    @(negedge clk);
    sample_en = 1'b0;
    chk({nm, ".done"}, done, 1);
  endtask

  initial begin
    vec_t v;
    pdat = '{15, 20, 30, 10, 20, 0, 30, 1, 0,
             45, 50, 55, 60, 65, 70, 75, 80};
    for (int i = 0; i < 17; i++)
      pmode[i] = (i == 5) ? MP : (i == 8) ? MS : MD;

    #2;
    chk_zero("reset");
    #10;
    rst_n = 1'b1;

    // samples outside RUN are ignored
    @(negedge clk);
    sample_en = 1'b1;
    dut_pc = 32'h77;
    @(posedge clk);
    #1;
    chk("idle_sample.mm", mismatch, 0);
    chk("idle_sample.err", err_cnt, 0);
    chk("idle_sample.busy", busy, 0);
    sample_en = 1'b0;

    // 1: correct trace; idx0 rewritten in the start cycle
    load(0, MD, 32'd100, 32'd15);
    for (int i = 1; i < 17; i++)
      load(i, pmode[i], 32'(4 * i), pdat[i]);
    load(17, ME, 32'd0, 32'd0);
    @(negedge clk);
    ld_en = 1'b1;
    ld_idx = '0;
    ld_mode = MD;
    ld_pc = 32'd0;
    ld_data = 32'd15;
    start = 1'b1;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    start = 1'b0;
    chk("s1.busy_on_start", busy, 1);
    build_good();
    apply("s1");
    chk("s1.pass", pass, 1);
    chk("s1.err", err_cnt, 0);
    chk("s1.fv", fail_valid, 0);

    // 2: bad data at idx 2
    build_good();
    q[2].dat = 32'd31;
    q[2].mm = 1'b1;
    for (int k = 2; k < q.size(); k++) q[k].err = 8'd1;
    start_run("s2");
    apply("s2");
    chk("s2.pass", pass, 0);
    chk("s2.fv", fail_valid, 1);
    chk("s2.fidx", fail_idx, 2);
    chk("s2.fpc", fail_pc, 8);
    chk("s2.fdata", fail_data, 31);

    // 3: bad PC at idx 3 and 5
    build_good();
    q[3].pc = 32'd13;
    q[5].pc = 32'd21;
    q[3].mm = 1'b1;
    q[5].mm = 1'b1;
    for (int k = 3; k < q.size(); k++)
      q[k].err = (k < 5) ? 8'd1 : 8'd2;
    start_run("s3");
    apply("s3");
    chk("s3.pass", pass, 0);
    chk("s3.err", err_cnt, 2);
    chk("s3.fidx", fail_idx, 3);
    chk("s3.fpc", fail_pc, 13);
    chk("s3.fdata", fail_data, 10);

    // 4: three stall cycles mid-run
    build_good();
    v.se = 1'b0;
    v.pc = 32'hdead;
    v.dat = 32'hbeef;
    v.mm = 1'b0;
    v.err = 8'd0;
    for (int k = 0; k < 3; k++) q.insert(7, v);
    start_run("s4");
    apply("s4");
    chk("s4.pass", pass, 1);
    chk("s4.fv", fail_valid, 0);

    // 6a: loads in DONE and RUN are dropped
    load(2, MD, 32'd8, 32'd999);
    start_run("s6a");
    load(4, MD, 32'd16, 32'd999);
    build_good();
    apply("s6a");
    chk("s6a.pass", pass, 1);

    // 6b: start+abort together
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("s6b.done_busy", {done, busy}, 0);
    start_run("s6b");
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("s6b.run_abort", {done, busy, pass}, 0);

    // 6c: async reset mid-run
    start_run("s6c");
    @(negedge clk);
    sample_en = 1'b1;
    dut_pc = 32'd1;
    dut_data = 32'd15;
    @(posedge clk);
    #1;
    chk("s6c.mm", mismatch, 1);
    chk("s6c.fpc", fail_pc, 1);
    @(negedge clk);
    sample_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("s6c.rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 5: full table, saturation, no wrap
    for (int i = 0; i < DEPTH; i++)
      load(i, MP, 32'(i), 32'd0);
    start_run("s5");
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      sample_en = 1'b1;
      dut_pc = (i < 300) ? 32'(i + 1) : 32'(i);
      dut_data = 32'd7;
      @(posedge clk);
      #1;
      chk($sformatf("s5.mm[%0d]", i), mismatch, i < 300);
      chk($sformatf("s5.err[%0d]", i), err_cnt,
          (i < 255) ? i + 1 : 255);
      chk($sformatf("s5.busy[%0d]", i), busy, i < DEPTH - 1);
    end
    chk("s5.done", done, 1);
    chk("s5.pass", pass, 0);
    chk("s5.fidx", fail_idx, 0);
    chk("s5.fpc", fail_pc, 1);
    @(negedge clk);
    dut_pc = 32'hffff;
    @(posedge clk);
    #1;
    chk("s5.post_mm", mismatch, 0);
    chk("s5.post_err", err_cnt, 255);
    chk("s5.post_done", done, 1);
    sample_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
